// File: rtl/rv32i_mem_access_if.sv
// Avalon-MM style data-memory bus between the access unit (master) and memory (slave).
interface rv32i_mem_access_if;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        mem_readdatavalid;

    modport master (
        output mem_address, mem_read, mem_write, mem_byteenable, mem_writedata,
        input  mem_waitrequest, mem_readdata, mem_readdatavalid
    );

    modport slave (
        input  mem_address, mem_read, mem_write, mem_byteenable, mem_writedata,
        output mem_waitrequest, mem_readdata, mem_readdatavalid
    );
endinterface

// File: rtl/rv32i_mem_access.sv
// RV32I data-memory access unit: runs one ALU load/store as a bus transaction with wait
// states, stalls the pipeline until it completes, and aborts on timeout.
module rv32i_mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                store,
    input  logic [31:0]         addr,
    input  logic [3:0]          st_be,
    input  logic [31:0]         wr_data,
    output logic                stall,
    output logic [31:0]         ld_data,
    output logic                bus_err,
    rv32i_mem_access_if.master  bus
);

    // A zero timeout still needs a legal counter width.
    localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StWrReq, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            read_q, read_d;
    logic            write_q, write_d;
    logic [31:0]     ld_data_q, ld_data_d;
    logic            bus_err_q, bus_err_d;
    logic            busy;
    logic            complete;
    logic            expire;

    assign expire = (TIMEOUT_CYCLES != 0) && (cnt_q == CntLast);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        read_d    = read_q;
        write_d   = write_q;
        ld_data_d = ld_data_q;
        bus_err_d = 1'b0;
        busy      = 1'b0;
        complete  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (load) begin
                    addr_d  = addr;
                    be_d    = 4'hF;
                    read_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = StRdReq;
                end else if (store) begin
                    addr_d  = addr;
                    be_d    = st_be;
                    wdata_d = wr_data;
                    write_d = 1'b1;
                    cnt_d   = '0;
                    state_d = StWrReq;
                end
            end
            StRdReq: begin
                busy = 1'b1;
                if (!bus.mem_waitrequest) begin
                    read_d = 1'b0;
                    if (bus.mem_readdatavalid) begin
                        ld_data_d = bus.mem_readdata;
                        complete  = 1'b1;
                        state_d   = StDone;
                    end else begin
                        state_d = StRdWait;
                    end
                end
            end
            StRdWait: begin
                busy = 1'b1;
                if (bus.mem_readdatavalid) begin
                    ld_data_d = bus.mem_readdata;
                    complete  = 1'b1;
                    state_d   = StDone;
                end
            end
            StWrReq: begin
                busy = 1'b1;
                if (!bus.mem_waitrequest) begin
                    write_d  = 1'b0;
                    complete = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Completion in the expiry cycle wins; otherwise abort and hold the counter.
        if (busy && !complete && expire) begin
            read_d    = 1'b0;
            write_d   = 1'b0;
            ld_data_d = 32'h0;
            bus_err_d = 1'b1;
            state_d   = StDone;
        end else if (busy && (TIMEOUT_CYCLES != 0)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= 32'h0;
            be_q      <= 4'h0;
            wdata_q   <= 32'h0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            ld_data_q <= 32'h0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            read_q    <= read_d;
            write_q   <= write_d;
            ld_data_q <= ld_data_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign stall = ((state_q == StIdle) && (load || store)) || (state_q == StRdReq) ||
                   (state_q == StRdWait) || (state_q == StWrReq);

    assign ld_data            = ld_data_q;
    assign bus_err            = bus_err_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_read       = read_q;
    assign bus.mem_write      = write_q;
    assign bus.mem_byteenable = be_q;
    assign bus.mem_writedata  = wdata_q;

endmodule

// File: tb/tb_rv32i_mem_access.sv
// Directed bench for rv32i_mem_access; the bench plays the memory slave cycle by cycle.
module tb_rv32i_mem_access;

    logic        clk;
    logic        reset;
    logic        load;
    logic        store;
    logic [31:0] addr;
    logic [3:0]  st_be;
    logic [31:0] wr_data;
    logic        stall;
    logic [31:0] ld_data;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    rv32i_mem_access_if bus ();

    rv32i_mem_access #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .store   (store),
        .addr    (addr),
        .st_be   (st_be),
        .wr_data (wr_data),
        .stall   (stall),
        .ld_data (ld_data),
        .bus_err (bus_err),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b1;
        load    = 1'b0;
        store   = 1'b0;
        addr    = 32'h0;
        st_be   = 4'h0;
        wr_data = 32'h0;
        bus.mem_waitrequest   = 1'b0;
        bus.mem_readdata      = 32'h0;
        bus.mem_readdatavalid = 1'b0;

        // Reset values
        tick();
        tick();
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_read", {31'h0, bus.mem_read}, 32'h0);
        chk("rst_write", {31'h0, bus.mem_write}, 32'h0);
        chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
        chk("rst_ld_data", ld_data, 32'h0);
        chk("rst_address", bus.mem_address, 32'h0);
        chk("rst_be", {28'h0, bus.mem_byteenable}, 32'h0);
        chk("rst_wdata", bus.mem_writedata, 32'h0);
        reset = 1'b0;
        tick();

        // 1: load, no wait states, data one cycle after accept
        load = 1'b1;
        addr = 32'h40;
        #1;
        chk("t1_stall_idle", {31'h0, stall}, 32'h1);
        tick();
        chk("t1_read", {31'h0, bus.mem_read}, 32'h1);
        chk("t1_address", bus.mem_address, 32'h40);
        chk("t1_be", {28'h0, bus.mem_byteenable}, 32'hF);
        chk("t1_stall_req", {31'h0, stall}, 32'h1);
        tick();
        chk("t1_read_clr", {31'h0, bus.mem_read}, 32'h0);
        chk("t1_stall_wait", {31'h0, stall}, 32'h1);
        bus.mem_readdatavalid = 1'b1;
        bus.mem_readdata      = 32'h12345678;
        tick();
        bus.mem_readdatavalid = 1'b0;
        #1;
        chk("t1_stall_done", {31'h0, stall}, 32'h0);
        chk("t1_ld_data", ld_data, 32'h12345678);
        chk("t1_bus_err", {31'h0, bus_err}, 32'h0);
        load = 1'b0;
        tick();
        chk("t1_ld_hold", ld_data, 32'h12345678);
        chk("t1_stall_idle2", {31'h0, stall}, 32'h0);

        // 2: store with four wait-state cycles
        store   = 1'b1;
        addr    = 32'h100;
        st_be   = 4'b0100;
        wr_data = 32'h00AB0000;
        bus.mem_waitrequest = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t2_write_held", {31'h0, bus.mem_write}, 32'h1);
            chk("t2_addr_held", bus.mem_address, 32'h100);
            chk("t2_be_held", {28'h0, bus.mem_byteenable}, 32'h4);
            chk("t2_wdata_held", bus.mem_writedata, 32'h00AB0000);
            chk("t2_stall", {31'h0, stall}, 32'h1);
            tick();
        end
        bus.mem_waitrequest = 1'b0;
        #1;
        chk("t2_write_5th", {31'h0, bus.mem_write}, 32'h1);
        tick();
        chk("t2_write_clr", {31'h0, bus.mem_write}, 32'h0);
        chk("t2_stall_done", {31'h0, stall}, 32'h0);
        chk("t2_bus_err", {31'h0, bus_err}, 32'h0);
        store = 1'b0;
        tick();

        // 3: load and store together, load wins
        load    = 1'b1;
        store   = 1'b1;
        addr    = 32'h200;
        st_be   = 4'hF;
        wr_data = 32'hDEADBEEF;
        tick();
        chk("t3_read", {31'h0, bus.mem_read}, 32'h1);
        chk("t3_no_write", {31'h0, bus.mem_write}, 32'h0);
        chk("t3_address", bus.mem_address, 32'h200);
        bus.mem_readdatavalid = 1'b1;
        bus.mem_readdata      = 32'hCAFEF00D;
        tick();
        bus.mem_readdatavalid = 1'b0;
        chk("t3_no_write_done", {31'h0, bus.mem_write}, 32'h0);
        chk("t3_ld_data", ld_data, 32'hCAFEF00D);
        chk("t3_stall_done", {31'h0, stall}, 32'h0);
        load  = 1'b0;
        store = 1'b0;
        tick();
        chk("t3_no_write_idle", {31'h0, bus.mem_write}, 32'h0);

        // 4: read data never returned, timeout of 8 cycles
        load = 1'b1;
        addr = 32'h300;
        tick();
        for (int i = 0; i < 7; i++) begin
            chk("t4_no_err_early", {31'h0, bus_err}, 32'h0);
            chk("t4_stall_busy", {31'h0, stall}, 32'h1);
            tick();
        end
        chk("t4_no_err_last", {31'h0, bus_err}, 32'h0);
        chk("t4_stall_last", {31'h0, stall}, 32'h1);
        tick();
        chk("t4_bus_err", {31'h0, bus_err}, 32'h1);
        chk("t4_ld_zero", ld_data, 32'h0);
        chk("t4_stall_drop", {31'h0, stall}, 32'h0);
        chk("t4_read_clr", {31'h0, bus.mem_read}, 32'h0);
        load = 1'b0;
        tick();
        chk("t4_err_pulse", {31'h0, bus_err}, 32'h0);

        // 5: reset in RD_WAIT, later readdatavalid ignored
        load = 1'b1;
        addr = 32'h400;
        tick();
        tick();
        chk("t5_stall_wait", {31'h0, stall}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        load  = 1'b0;
        #1;
        chk("t5_stall", {31'h0, stall}, 32'h0);
        chk("t5_read", {31'h0, bus.mem_read}, 32'h0);
        chk("t5_address", bus.mem_address, 32'h0);
        chk("t5_be", {28'h0, bus.mem_byteenable}, 32'h0);
        chk("t5_ld_data", ld_data, 32'h0);
        bus.mem_readdatavalid = 1'b1;
        bus.mem_readdata      = 32'h55AA55AA;
        tick();
        bus.mem_readdatavalid = 1'b0;
        chk("t5_stray_ld", ld_data, 32'h0);
        chk("t5_stray_err", {31'h0, bus_err}, 32'h0);
        tick();
        chk("t5_stray_ld2", ld_data, 32'h0);
        chk("t5_stray_err2", {31'h0, bus_err}, 32'h0);

        // 6: back-to-back load then store, zero wait states
        load = 1'b1;
        addr = 32'h500;
        tick();
        chk("t6_read", {31'h0, bus.mem_read}, 32'h1);
        chk("t6_rd_addr", bus.mem_address, 32'h500);
        bus.mem_readdatavalid = 1'b1;
        bus.mem_readdata      = 32'h11223344;
        tick();
        bus.mem_readdatavalid = 1'b0;
        chk("t6_ld_data", ld_data, 32'h11223344);
        chk("t6_stall_done", {31'h0, stall}, 32'h0);
        load    = 1'b0;
        store   = 1'b1;
        addr    = 32'h504;
        st_be   = 4'b0011;
        wr_data = 32'h0000BEEF;
        tick();
        chk("t6_idle_stall", {31'h0, stall}, 32'h1);
        chk("t6_idle_write", {31'h0, bus.mem_write}, 32'h0);
        chk("t6_idle_read", {31'h0, bus.mem_read}, 32'h0);
        tick();
        chk("t6_write", {31'h0, bus.mem_write}, 32'h1);
        chk("t6_wr_addr", bus.mem_address, 32'h504);
        chk("t6_wr_be", {28'h0, bus.mem_byteenable}, 32'h3);
        chk("t6_wr_data", bus.mem_writedata, 32'h0000BEEF);
        tick();
        chk("t6_write_clr", {31'h0, bus.mem_write}, 32'h0);
        chk("t6_stall_done2", {31'h0, stall}, 32'h0);
        chk("t6_ld_keep", ld_data, 32'h11223344);
        store = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
